// File: rtl/mole_game_ctrl.sv
// Reaction-game controller: raises one pseudo-random target at a time, scores
// synchronised button hits against it and counts missed raises up to a game-over limit.

module mole_hit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic pulse
);
    logic s1_q, s2_q, prev_q, pulse_q;
    logic s1_d, s2_d, prev_d, pulse_d;

    // Registered edge pulse: the FSM sees it 3 edges after the pin rises.
    always_comb begin
        s1_d    = pin;
        s2_d    = s1_q;
        prev_d  = s2_q;
        pulse_d = s2_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
endmodule

module mole_game_ctrl #(
    parameter int             NUM_MOLES   = 4,
    parameter int             UP_CYCLES   = 11,
    parameter int             DOWN_CYCLES = 11,
    parameter int             SCORE_W     = 8,
    parameter int             NUM_LEDS    = 6,
    parameter int             MAX_MISSES  = 3,
    parameter logic [7:0]     LFSR_SEED   = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] hit_in,
    output logic [NUM_MOLES-1:0] mole_out,
    output logic [SCORE_W-1:0]   score,
    output logic [3:0]           misses,
    output logic [NUM_LEDS-1:0]  led,
    output logic                 game_over,
    output logic                 busy
);
    localparam int TMAX    = (UP_CYCLES > DOWN_CYCLES) ? UP_CYCLES : DOWN_CYCLES;
    localparam int TIMER_W = $clog2(TMAX);
    localparam int IDX_W   = $clog2(NUM_MOLES);

    typedef enum logic [1:0] {S_IDLE, S_DOWN, S_UP, S_OVER} state_t;

    logic [NUM_MOLES-1:0] hit_pulse;

    for (genvar i = 0; i < NUM_MOLES; i++) begin : g_sync
        mole_hit_sync u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .pin   (hit_in[i]),
            .pulse (hit_pulse[i])
        );
    end

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_MOLES-1:0] mole_q, mole_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [3:0]           misses_q, misses_d;
    logic [NUM_LEDS-1:0]  led_q, led_d;
    logic                 game_over_q, game_over_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        mole_d   = mole_q;
        score_d  = score_q;
        misses_d = misses_q;
        // Galois form of x^8+x^6+x^5+x^4+1, free-running.
        lfsr_d   = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

        case (state_q)
            S_IDLE, S_OVER: begin
                mole_d = '0;
                if (start) begin
                    state_d  = S_DOWN;
                    timer_d  = '0;
                    score_d  = '0;
                    misses_d = '0;
                end
            end
            S_DOWN: begin
                if (timer_q == TIMER_W'(DOWN_CYCLES - 1)) begin
                    state_d = S_UP;
                    timer_d = '0;
                    idx_d   = IDX_W'(32'(lfsr_q) % NUM_MOLES);
                    mole_d  = NUM_MOLES'(1) << idx_d;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_UP: begin
                // A matching hit wins over a simultaneous timeout.
                if (hit_pulse[idx_q]) begin
                    score_d = (score_q == '1) ? score_q : score_q + 1'b1;
                    mole_d  = '0;
                    state_d = S_DOWN;
                    timer_d = '0;
                end else if (timer_q == TIMER_W'(UP_CYCLES - 1)) begin
                    mole_d   = '0;
                    misses_d = misses_q + 4'd1;
                    timer_d  = '0;
                    state_d  = (misses_d == 4'(MAX_MISSES)) ? S_OVER : S_DOWN;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        game_over_d = (state_d == S_OVER);
        busy_d      = (state_d == S_DOWN) || (state_d == S_UP);
        led_d       = NUM_LEDS'(1) << (32'(score_q) % NUM_LEDS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            lfsr_q      <= LFSR_SEED;
            idx_q       <= '0;
            mole_q      <= '0;
            score_q     <= '0;
            misses_q    <= '0;
            led_q       <= NUM_LEDS'(1);
            game_over_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            lfsr_q      <= lfsr_d;
            idx_q       <= idx_d;
            mole_q      <= mole_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            led_q       <= led_d;
            game_over_q <= game_over_d;
            busy_q      <= busy_d;
        end
    end

    assign mole_out  = mole_q;
    assign score     = score_q;
    assign misses    = misses_q;
    assign led       = led_q;
    assign game_over = game_over_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl; a second instance with SCORE_W=3 shares the
// stimulus to cover score saturation.

module tb_mole_game_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] hit_in = 4'b0;

    logic [3:0] mole, mole_s;
    logic [7:0] score;
    logic [2:0] score_s;
    logic [3:0] misses, misses_s;
    logic [5:0] led, led_s;
    logic       game_over, game_over_s, busy, busy_s;

    mole_game_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hit_in(hit_in),
        .mole_out(mole), .score(score), .misses(misses), .led(led),
        .game_over(game_over), .busy(busy)
    );

    mole_game_ctrl #(.SCORE_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .hit_in(hit_in),
        .mole_out(mole_s), .score(score_s), .misses(misses_s), .led(led_s),
        .game_over(game_over_s), .busy(busy_s)
    );

    always #5 clk = ~clk;

    // Edges seen since the last reset release; drives the LFSR golden model.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int total = 0;
    int bad   = 0;
    int tgt   = 0;
    int sc    = 0;
    int ms    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lfsr_after(input int n);
        logic [7:0] l;
        l = 8'hA5;
        for (int i = 0; i < n; i++)
            l = {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
        return l;
    endfunction

    function automatic int sat3(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    // n = edges remaining until the raise edge.
    task automatic rise_after(input int n);
        repeat (n - 1) tick();
        chk("down_quiet", 32'(mole), 0);
        tick();
        tgt = int'(lfsr_after(cyc - 1)) % 4;
        chk("raise", 32'(mole), 32'(1) << tgt);
        chk("raise_s", 32'(mole_s), 32'(1) << tgt);
    endtask

    // Called at the raise sample point; press mask k edges later.
    task automatic do_hit(input int k, input logic [3:0] mask);
        repeat (k) tick();
        hit_in = mask;
        repeat (3) tick();
        chk("hit_pending_mole", 32'(mole), 32'(1) << tgt);
        chk("hit_pending_score", 32'(score), 32'(sc));
        tick();
        sc++;
        chk("hit_mole_clear", 32'(mole), 0);
        chk("hit_score", 32'(score), 32'(sc));
        chk("hit_score_s", 32'(score_s), 32'(sat3(sc)));
        chk("hit_misses", 32'(misses), 32'(ms));
        hit_in = 4'b0;
        tick();
        chk("hit_led", 32'(led), 32'(1) << (sc % 6));
        chk("hit_led_s", 32'(led_s), 32'(1) << (sat3(sc) % 6));
        rise_after(10);
    endtask

    task automatic miss(input logic [3:0] mask);
        repeat (2) tick();
        hit_in = mask;
        repeat (8) tick();
        chk("miss_last_up", 32'(mole), 32'(1) << tgt);
        tick();
        ms++;
        hit_in = 4'b0;
        chk("miss_mole_clear", 32'(mole), 0);
        chk("miss_count", 32'(misses), 32'(ms));
        chk("miss_score", 32'(score), 32'(sc));
        if (ms == 3) begin
            chk("over_flag", 32'(game_over), 1);
            chk("over_busy", 32'(busy), 0);
        end else begin
            chk("miss_busy", 32'(busy), 1);
            rise_after(11);
        end
    endtask

    task automatic restart_held();
        start = 1'b1;
        tick();
        sc = 0;
        ms = 0;
        chk("restart_busy", 32'(busy), 1);
        chk("restart_over", 32'(game_over), 0);
        chk("restart_score", 32'(score), 0);
        chk("restart_misses", 32'(misses), 0);
        tick();
        chk("restart_led", 32'(led), 32'h01);
        tick();
        start = 1'b0;
        rise_after(9);
    endtask

    initial begin
        #23;
        chk("rst_mole", 32'(mole), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_misses", 32'(misses), 0);
        chk("rst_led", 32'(led), 32'h01);
        chk("rst_over", 32'(game_over), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_busy", 32'(busy), 0);

        // single-cycle start, first raise, then three unanswered raises
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_mole", 32'(mole), 0);
        rise_after(11);
        repeat (3) miss(4'b0);
        chk("over_score", 32'(score), 0);
        chk("over_led", 32'(led), 32'h01);

        // second game: hits, wrong buttons, coincident timeout, saturation
        restart_held();
        do_hit(2, 4'(1 << tgt));
        miss(4'(1 << ((tgt + 1) % 4)));
        do_hit(2, 4'((1 << tgt) | (1 << ((tgt + 2) % 4))));
        do_hit(7, 4'(1 << tgt));
        repeat (4) do_hit(1, 4'(1 << tgt));
        chk("seven_led", 32'(led), 32'h02);
        repeat (2) do_hit(1, 4'(1 << tgt));
        chk("sat_score_s", 32'(score_s), 7);
        chk("sat_led_s", 32'(led_s), 32'h02);
        chk("nine_led", 32'(led), 32'h08);
        miss(4'b0);
        miss(4'b0);
        repeat (3) tick();
        chk("frozen_score", 32'(score), 9);
        chk("frozen_misses", 32'(misses), 3);
        chk("frozen_mole", 32'(mole), 0);

        // restart from OVER with start held, then async reset mid-UP
        restart_held();
        do_hit(2, 4'(1 << tgt));
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_mole", 32'(mole), 0);
        chk("async_score", 32'(score), 0);
        chk("async_led", 32'(led), 32'h01);
        chk("async_busy", 32'(busy), 0);
        chk("async_over", 32'(game_over), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_rst_busy", 32'(busy), 1);
        rise_after(11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mole_game_ctrl.md
Name: mole_game_ctrl

Overview:
Parametrised multi-target reaction-game controller. Raises one of NUM_MOLES target outputs at a time, chosen pseudo-randomly. Scores synchronised button hits against the raised target and counts missed targets up to a game-over limit. Drives a one-hot score-modulo LED bar. Sits between the board buttons/LEDs and any top-level display logic.

Parameters:
NUM_MOLES, 4, number of target outputs and hit inputs (2..8)
UP_CYCLES, 11, clock cycles a target stays raised if not hit (>=2)
DOWN_CYCLES, 11, clock cycles all targets stay lowered between raises (>=2)
SCORE_W, 8, score counter width
NUM_LEDS, 6, LED bar length; the LED index shown is score mod NUM_LEDS
MAX_MISSES, 3, misses that end the game (1..15)
LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  synchronous level, sampled each cycle; starts or restarts a game
hit_in  in  NUM_MOLES  raw asynchronous buttons, one per target
mole_out  out  NUM_MOLES  registered, one-hot or zero; the raised target
score  out  SCORE_W  registered hit count, saturating
misses  out  4  registered miss count
led  out  NUM_LEDS  registered one-hot, bit (score mod NUM_LEDS)
game_over  out  1  registered; high in OVER state
busy  out  1  registered; high in DOWN or UP

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, timer=0, LFSR=LFSR_SEED.
  - mole_out=0, score=0, misses=0, game_over=0, busy=0.
  - led = one-hot bit 0.
  - Synchronisers and edge-detect registers are cleared.
  - Reset mid-game aborts the game immediately.
- Input conditioning, per hit_in bit:
  - 2-flop synchroniser, then rising-edge detect, giving a 1-cycle hit pulse.
  - Latency: the pulse appears 3 clk edges after the pin rises.
  - A held button yields exactly one pulse.
- LFSR:
  - 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1.
  - Advances every cycle out of reset.
  - Target index = LFSR[7:0] mod NUM_MOLES, sampled on the DOWN->UP transition.
- FSM states: IDLE, DOWN, UP, OVER.
  - IDLE: all outputs idle. start=1 -> DOWN, timer=0, score=0, misses=0.
  - DOWN:
    - timer increments each cycle.
    - At timer==DOWN_CYCLES-1 -> UP, timer=0, target index latched.
    - Hits are ignored.
  - UP:
    - mole_out = one-hot of the latched index.
    - Asserted on the first UP cycle, for at most UP_CYCLES cycles.
    - Hit pulse on the latched index:
      - score+1, saturating at 2^SCORE_W-1.
      - mole_out=0 next cycle, -> DOWN, timer=0.
    - Hit pulses on other bits are ignored; no penalty.
    - timer==UP_CYCLES-1 with no matching hit:
      - misses+1.
      - If the new misses==MAX_MISSES -> OVER, else -> DOWN, timer=0.
    - A matching hit in the same cycle as timeout counts as a hit; no miss is recorded.
    - Multiple simultaneous hit bits including the target count as a hit (one increment).
  - OVER:
    - mole_out=0, game_over=1, score and misses frozen.
    - start=1 -> DOWN with score=0, misses=0.
- start while in DOWN or UP is ignored.
- led updates the cycle after score changes (one extra register stage).
- Score saturation: led keeps following the saturated value mod NUM_LEDS.
- busy=1 exactly when state is DOWN or UP.

Test Plan:
1. Reset released, start pulsed 1 cycle -> busy=1 next cycle; first mole_out nonzero exactly DOWN_CYCLES (11) cycles later; one-hot index equals the golden LFSR model.
2. No hits for 3 raises -> each raise lasts 11 cycles; misses 1,2,3; game_over=1 after third timeout; score=0; led=000001.
3. Press the correct button 2 cycles into a raise -> hit pulse 3 edges later; mole_out clears the following cycle; score=1; led=000010 one cycle after; next raise 11 cycles later.
4. Press a wrong button during UP, then no hit -> score unchanged; misses+1 at timeout. Press correct and wrong buttons together -> score+1.
5. Correct hit pulse coincides with the last UP cycle -> score+1, misses unchanged. Run 7 hits (NUM_LEDS=6) -> led=000010; with SCORE_W=3, 9 hits -> score=7 saturated, led bit 1.
6. rst_n low mid-UP (asynchronous, between edges) -> all outputs return to reset values immediately. Start held high in OVER -> restart with score=0, misses=0.
